// File: rtl/fcpu_pkg.sv
// Shared core constants, memory/IO opcodes and the mmu state type.
// Opcode classification helpers keep the mmu decode readable.
package fcpu_pkg;

    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_LOAD   = 6'h10;
    localparam logic [INSTR_W-1:0] I_LOADB  = 6'h11;
    localparam logic [INSTR_W-1:0] I_LOADR  = 6'h12;
    localparam logic [INSTR_W-1:0] I_STORE  = 6'h14;
    localparam logic [INSTR_W-1:0] I_STOREB = 6'h15;
    localparam logic [INSTR_W-1:0] I_STORER = 6'h16;
    localparam logic [INSTR_W-1:0] I_INPUT  = 6'h18;
    localparam logic [INSTR_W-1:0] I_OUTPUT = 6'h19;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_IN   = 3'd2,
        S_OUT  = 3'd3,
        S_CDB  = 3'd4
    } mmu_state_t;

    function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
        return (op == I_LOAD) || (op == I_LOADB) || (op == I_LOADR);
    endfunction

    function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
        return (op == I_STORE) || (op == I_STOREB) || (op == I_STORER);
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port word RAM with registered read; deliberately reset-free so
// synthesis maps it onto block RAM.
module dmem_bram
  import fcpu_pkg::*;
#(
  parameter int DMEM_ADDR_W = 14,
  parameter     DMEM_INIT   = ""
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [DMEM_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o
);

  logic [DATA_W-1:0] mem [2**DMEM_ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/mmu.sv
// Memory/IO back-end: one request in flight, word RAM or byte-stream IO,
// load/input results returned on a held valid/ready CDB channel.
module mmu
    import fcpu_pkg::*;
#(
    parameter int DMEM_ADDR_W = 14,
    parameter     DMEM_INIT   = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RSV_ID_W-1:0] mmu_rsv_id,
    input  logic                mmu_valid,
    input  logic [DATA_W-1:0]   mmu_data,
    input  logic [DATA_W-1:0]   mmu_addr,
    input  logic [INSTR_W-1:0]  mmu_opcode,
    output logic                mmu_ready,
    output logic [CDB_W-1:0]    mmu_cdb,
    output logic                mmu_cdb_valid,
    input  logic                mmu_cdb_ready,
    input  logic [7:0]          io_in_data,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    output logic [7:0]          io_out_data,
    output logic                io_out_valid,
    input  logic                io_out_ready
);

    mmu_state_t          state_q, state_d;
    logic [RSV_ID_W-1:0] rsv_q, rsv_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          out_q, out_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // Addresses wrap modulo the RAM depth; the upper bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mmu_addr[DATA_W-1:DMEM_ADDR_W];

    dmem_bram #(
        .DMEM_ADDR_W(DMEM_ADDR_W),
        .DMEM_INIT  (DMEM_INIT)
    ) u_dmem (
        .clk    (clk),
        .we_i   (mem_we),
        .addr_i (mmu_addr[DMEM_ADDR_W-1:0]),
        .wdata_i(mmu_data),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rsv_q   <= '0;
            data_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rsv_q   <= rsv_d;
            data_q  <= data_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rsv_d   = rsv_q;
        data_d  = data_q;
        out_d   = out_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mmu_valid) begin
                    if (is_load_op(mmu_opcode)) begin
                        rsv_d   = mmu_rsv_id;
                        state_d = S_RD;
                    end else if (is_store_op(mmu_opcode)) begin
                        mem_we = 1'b1;
                    end else if (mmu_opcode == I_INPUT) begin
                        rsv_d   = mmu_rsv_id;
                        state_d = S_IN;
                    end else if (mmu_opcode == I_OUTPUT) begin
                        out_d   = mmu_data[7:0];
                        state_d = S_OUT;
                    end
                end
            end
            S_RD: begin
                data_d  = mem_rdata;
                state_d = S_CDB;
            end
            S_IN: begin
                if (io_in_valid) begin
                    data_d  = {{(DATA_W-8){1'b0}}, io_in_data};
                    state_d = S_CDB;
                end
            end
            S_OUT: begin
                if (io_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_CDB: begin
                if (mmu_cdb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mmu_ready     = (state_q == S_IDLE);
    assign mmu_cdb_valid = (state_q == S_CDB);
    assign mmu_cdb       = {rsv_q, data_q};
    assign io_in_ready   = (state_q == S_IN);
    assign io_out_valid  = (state_q == S_OUT);
    assign io_out_data   = out_q;

endmodule

// File: tb/tb_mmu.sv
// Directed plus randomized bench for mmu, checked against a word-array
// memory model and an expected-result queue.
`timescale 1ns/1ps
module tb_mmu;
    import fcpu_pkg::*;

    localparam int DEPTH = 2**14;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [RSV_ID_W-1:0] mmu_rsv_id = '0;
    logic                mmu_valid = 1'b0;
    logic [DATA_W-1:0]   mmu_data = '0;
    logic [DATA_W-1:0]   mmu_addr = '0;
    logic [INSTR_W-1:0]  mmu_opcode = '0;
    logic                mmu_ready;
    logic [CDB_W-1:0]    mmu_cdb;
    logic                mmu_cdb_valid;
    logic                mmu_cdb_ready = 1'b0;
    logic [7:0]          io_in_data = '0;
    logic                io_in_valid = 1'b0;
    logic                io_in_ready;
    logic [7:0]          io_out_data;
    logic                io_out_valid;
    logic                io_out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [CDB_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] ref_mem[int];

    mmu dut (
        .clk          (clk),
        .rst          (rst),
        .mmu_rsv_id   (mmu_rsv_id),
        .mmu_valid    (mmu_valid),
        .mmu_data     (mmu_data),
        .mmu_addr     (mmu_addr),
        .mmu_opcode   (mmu_opcode),
        .mmu_ready    (mmu_ready),
        .mmu_cdb      (mmu_cdb),
        .mmu_cdb_valid(mmu_cdb_valid),
        .mmu_cdb_ready(mmu_cdb_ready),
        .io_in_data   (io_in_data),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_out_data  (io_out_data),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // driver: hold the request until accepted; returns just after the accept edge
    task automatic send_req(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] id,
                            input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
        int n = 0;
        mmu_opcode = op;
        mmu_rsv_id = id;
        mmu_addr   = addr;
        mmu_data   = data;
        mmu_valid  = 1'b1;
        while (!mmu_ready && n < 50) begin
            tick();
            n++;
        end
        if (!mmu_ready) check("req_accept_timeout", 64'd0, 64'd1);
        tick();
        mmu_valid  = 1'b0;
        mmu_opcode = 6'h3F;
    endtask

    task automatic do_store(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
        send_req(I_STORE, '0, addr, data);
        ref_mem[int'(addr % DEPTH)] = data;
    endtask

    task automatic expect_load(input logic [RSV_ID_W-1:0] id, input logic [DATA_W-1:0] addr);
        exp_q.push_back({id, ref_mem[int'(addr % DEPTH)]});
    endtask

    // scoreboard: wait for the result, hold off the grant, compare, handshake
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int n = 0;
        logic [CDB_W-1:0] exp;
        while (!mmu_cdb_valid && n < 100) begin
            tick();
            n++;
        end
        if (!mmu_cdb_valid) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_cdb"}, 64'(mmu_cdb), 64'(exp));
        repeat (hold) tick();
        check({tag, "_cdb_held"}, 64'(mmu_cdb), 64'(exp));
        check({tag, "_valid_held"}, 64'(mmu_cdb_valid), 64'd1);
        check({tag, "_ready_busy"}, 64'(mmu_ready), 64'd0);
        mmu_cdb_ready = 1'b1;
        tick();
        mmu_cdb_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(mmu_cdb_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(mmu_ready), 64'd1);
    endtask

    task automatic do_input(input logic [RSV_ID_W-1:0] id, input logic [7:0] b, input int delay);
        int n = 0;
        send_req(I_INPUT, id, '0, '0);
        exp_q.push_back({id, 24'd0, b});
        repeat (delay) tick();
        io_in_data  = b;
        io_in_valid = 1'b1;
        while (!io_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!io_in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        tick();
        io_in_valid = 1'b0;
        check("in_ready_after_hs", 64'(io_in_ready), 64'd0);
    endtask

    task automatic do_output(input logic [DATA_W-1:0] data, input int delay);
        send_req(I_OUTPUT, '0, '0, data);
        repeat (delay) tick();
        check("out_valid", 64'(io_out_valid), 64'd1);
        check("out_data", 64'(io_out_data), 64'(data[7:0]));
        check("out_no_cdb", 64'(mmu_cdb_valid), 64'd0);
        check("out_ready_busy", 64'(mmu_ready), 64'd0);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        check("out_valid_drop", 64'(io_out_valid), 64'd0);
        check("out_ready_back", 64'(mmu_ready), 64'd1);
    endtask

    initial begin
        // reset values
        #2;
        check("rst_cdb_valid", 64'(mmu_cdb_valid), 64'd0);
        check("rst_cdb", 64'(mmu_cdb), 64'd0);
        check("rst_in_ready", 64'(io_in_ready), 64'd0);
        check("rst_out_valid", 64'(io_out_valid), 64'd0);
        check("rst_out_data", 64'(io_out_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_release_ready", 64'(mmu_ready), 64'd1);

        // store then load of the same word on the very next cycle
        do_store(32'd5, 32'hDEADBEEF);
        check("store_ready_stays", 64'(mmu_ready), 64'd1);
        send_req(I_LOAD, 4'd3, 32'd5, '0);
        expect_load(4'd3, 32'd5);
        check("load_ready_busy", 64'(mmu_ready), 64'd0);
        check("load_no_early_valid", 64'(mmu_cdb_valid), 64'd0);
        collect("load5", 1, 0);

        // wrapped address and a long-held grant
        send_req(I_LOADB, 4'd7, 32'h4005, '0);
        expect_load(4'd7, 32'h4005);
        collect("load_wrap", 1, 10);

        // reset while the read is in flight, then while the result is waiting
        send_req(I_LOAD, 4'd4, 32'd5, '0);
        rst = 1'b1;
        #1;
        check("rst_rd_valid", 64'(mmu_cdb_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_rd_ready", 64'(mmu_ready), 64'd1);
        send_req(I_LOADR, 4'd4, 32'd5, '0);
        tick();
        check("pre_rst_cdb_valid", 64'(mmu_cdb_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_cdb_valid_async", 64'(mmu_cdb_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_cdb_ready", 64'(mmu_ready), 64'd1);
        send_req(I_LOAD, 4'd9, 32'd5, '0);
        expect_load(4'd9, 32'd5);
        collect("load_after_rst", 1, 2);

        // input byte that arrives late
        check("in_ready_idle", 64'(io_in_ready), 64'd0);
        send_req(I_INPUT, 4'd2, '0, '0);
        exp_q.push_back({4'd2, 32'h41});
        repeat (20) tick();
        check("in_ready_waiting", 64'(io_in_ready), 64'd1);
        check("in_no_cdb_yet", 64'(mmu_cdb_valid), 64'd0);
        io_in_data  = 8'h41;
        io_in_valid = 1'b1;
        tick();
        io_in_valid = 1'b0;
        check("in_ready_after", 64'(io_in_ready), 64'd0);
        collect("input41", 0, 1);

        // output with back-pressure
        do_output(32'h12345678, 5);

        // unknown opcode is swallowed
        send_req(6'h3F, 4'd5, 32'd5, 32'hFFFF_FFFF);
        check("unk_ready", 64'(mmu_ready), 64'd1);
        check("unk_no_cdb", 64'(mmu_cdb_valid), 64'd0);
        check("unk_no_in", 64'(io_in_ready), 64'd0);
        check("unk_no_out", 64'(io_out_valid), 64'd0);
        tick();
        check("unk_still_ready", 64'(mmu_ready), 64'd1);
        check("unk_still_no_cdb", 64'(mmu_cdb_valid), 64'd0);

        // back-to-back stores fill a small window, then random traffic
        for (int i = 0; i < 32; i++) begin
            do_store(32'(i), $urandom());
        end
        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [DATA_W-1:0] a;
            logic [RSV_ID_W-1:0] id;
            kind = $urandom_range(0, 3);
            a    = 32'($urandom_range(0, 31)) + (32'($urandom_range(0, 7)) << 14);
            id   = 4'($urandom_range(0, 15));
            case (kind)
                0: do_store(a, $urandom());
                1: begin
                    send_req(($urandom_range(0, 1) == 1) ? I_LOADR : I_LOAD, id, a, '0);
                    expect_load(id, a);
                    collect("rand_load", 1, $urandom_range(0, 4));
                end
                2: begin
                    do_input(id, 8'($urandom_range(0, 255)), $urandom_range(0, 5));
                    collect("rand_input", -1, $urandom_range(0, 3));
                end
                default: do_output($urandom(), $urandom_range(0, 4));
            endcase
        end
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
